// File: rtl/reg_write_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : reg_arb_pkg
// Brief    : Shared types and constants for the reg_write_arbiter block:
//            FSM state encoding, lock burst limit, default widths and the
//            modulo-increment helper used by the round-robin search.
// Revision : 1.0 - initial release
// ============================================================================
package reg_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        WRITE = 2'd2
    } state_t;

    // Longest burst a locked requester may hold before it is forced to yield.
    localparam int LOCK_MAX = 16;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_DW      = 8;
    localparam int DEF_IDW     = 2;

    // (base + off) mod n for base, off in [0, n).
    function automatic int rr_index(input int base, input int off, input int n);
        int s;
        s = base + off;
        return (s >= n) ? (s - n) : s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/reg_write_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : reg_write_arbiter_if
// Brief    : Requester-side bus of the shared register: req/data/lock from
//            the masters, grant and write status back from the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface reg_write_arbiter_if
    import reg_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int DW      = DEF_DW,
    parameter int IDW     = DEF_IDW
);
    logic [NUM_REQ-1:0]    req;
    logic [NUM_REQ*DW-1:0] d;
    logic [NUM_REQ-1:0]    lock;
    logic [NUM_REQ-1:0]    gnt;
    logic [DW-1:0]         q;
    logic                  wr_done;
    logic [IDW-1:0]        wr_id;
    logic                  busy;

    modport master (
        output req, d, lock,
        input  gnt, q, wr_done, wr_id, busy
    );

    modport slave (
        input  req, d, lock,
        output gnt, q, wr_done, wr_id, busy
    );
endinterface
`default_nettype wire

// File: rtl/reg_write_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Brief    : Combinational round-robin picker. Searches i_req starting at
//            i_rr_ptr with increasing index, wrapping NUM_REQ-1 -> 0.
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick
    import reg_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int IDW     = DEF_IDW
) (
    input  wire logic [NUM_REQ-1:0] i_req,
    input  wire logic [IDW-1:0]     i_rr_ptr,
    output logic                    o_any,
    output logic [IDW-1:0]          o_winner
);

    assign o_any = |i_req;

    // Walk offsets from farthest to nearest so the closest requester to the
    // pointer is the last (and therefore winning) assignment.
    always_comb begin
        o_winner = '0;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            if (i_req[rr_index(int'(i_rr_ptr), off, NUM_REQ)]) begin
                o_winner = IDW'(rr_index(int'(i_rr_ptr), off, NUM_REQ));
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/reg_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : reg_write_arbiter
// Brief    : Round-robin arbiter sharing one DW-bit holding register among
//            NUM_REQ writers. IDLE -> GRANT (one-cycle gnt, data captured)
//            -> WRITE (q updated, wr_done pulse), back-to-back under load.
//            Optional macro ARB_LOCK_EN: a locked winner is re-granted for up
//            to LOCK_MAX consecutive writes; without it lock is ignored.
// Revision : 1.0 - initial release
// ============================================================================
module reg_write_arbiter
    import reg_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int DW      = DEF_DW,
    parameter int IDW     = DEF_IDW
) (
    input wire logic            sclk,
    input wire logic            rst,
    reg_write_arbiter_if.slave  bus
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [NUM_REQ-1:0] r_gnt;
    logic [NUM_REQ-1:0] w_gnt_nxt;
    logic [IDW-1:0]     r_win;
    logic [IDW-1:0]     w_win_nxt;
    logic [IDW-1:0]     r_rr_ptr;
    logic [IDW-1:0]     w_rr_ptr_nxt;
    logic [IDW-1:0]     w_win_inc;
    logic [IDW-1:0]     r_wr_id;
    logic [DW-1:0]      r_q;
    logic               w_capture;
    logic               w_relock;

    logic [NUM_REQ-1:0] w_pick_req;
    logic [IDW-1:0]     w_pick_ptr;
    logic               w_pick_any;
    logic [IDW-1:0]     w_pick_win;

    assign w_win_inc = IDW'(rr_index(int'(r_win), 1, NUM_REQ));

    // Arbitration inputs: in WRITE the current winner's request is stale
    // (it has only just seen gnt), so it is masked and the search starts
    // just past it, giving the winner lowest priority.
    always_comb begin
        w_pick_req = bus.req;
        w_pick_ptr = r_rr_ptr;
        if (r_state == WRITE) begin
            w_pick_req[r_win] = 1'b0;
            w_pick_ptr        = w_win_inc;
        end
    end

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_rr_pick (
        .i_req    (w_pick_req),
        .i_rr_ptr (w_pick_ptr),
        .o_any    (w_pick_any),
        .o_winner (w_pick_win)
    );

`ifdef ARB_LOCK_EN
    localparam logic [4:0] c_LOCK_MAX = 5'(LOCK_MAX);

    logic [4:0] r_burst;
    logic [4:0] w_burst_nxt;

    // A locked, still-requesting winner keeps the register until its burst
    // (counting the write in progress) reaches the limit.
    assign w_relock = bus.lock[r_win] & bus.req[r_win] & (r_burst < c_LOCK_MAX);

    // Burst length of the current winner, including the pending write.
    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            r_burst <= '0;
        end else begin
            r_burst <= w_burst_nxt;
        end
    end
`else
    logic w_unused_lock;

    assign w_relock      = 1'b0;
    assign w_unused_lock = ^bus.lock;
`endif

    // Next-state, grant, winner and pointer decode.
    always_comb begin
        w_state_nxt  = r_state;
        w_gnt_nxt    = '0;
        w_win_nxt    = r_win;
        w_rr_ptr_nxt = r_rr_ptr;
        w_capture    = 1'b0;
`ifdef ARB_LOCK_EN
        w_burst_nxt  = r_burst;
`endif
        case (r_state)
            IDLE: begin
                if (w_pick_any) begin
                    w_state_nxt           = GRANT;
                    w_gnt_nxt[w_pick_win] = 1'b1;
                    w_win_nxt             = w_pick_win;
`ifdef ARB_LOCK_EN
                    w_burst_nxt           = 5'd1;
`endif
                end
            end
            GRANT: begin
                w_capture   = 1'b1;
                w_state_nxt = WRITE;
            end
            WRITE: begin
                if (w_relock) begin
                    w_state_nxt      = GRANT;
                    w_gnt_nxt[r_win] = 1'b1;
`ifdef ARB_LOCK_EN
                    w_burst_nxt      = r_burst + 5'd1;
`endif
                end else begin
                    w_rr_ptr_nxt = w_win_inc;
                    if (w_pick_any) begin
                        w_state_nxt           = GRANT;
                        w_gnt_nxt[w_pick_win] = 1'b1;
                        w_win_nxt             = w_pick_win;
`ifdef ARB_LOCK_EN
                        w_burst_nxt           = 5'd1;
`endif
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Grant, winner, pointer and the shared register; data is taken at the
    // end of GRANT so q and wr_id change together on entry to WRITE.
    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            r_gnt    <= '0;
            r_win    <= '0;
            r_rr_ptr <= '0;
            r_q      <= '0;
            r_wr_id  <= '0;
        end else begin
            r_gnt    <= w_gnt_nxt;
            r_win    <= w_win_nxt;
            r_rr_ptr <= w_rr_ptr_nxt;
            if (w_capture) begin
                r_q     <= bus.d[int'(r_win)*DW +: DW];
                r_wr_id <= r_win;
            end
        end
    end

    assign bus.gnt     = r_gnt;
    assign bus.q       = r_q;
    assign bus.wr_done = (r_state == WRITE);
    assign bus.wr_id   = r_wr_id;
    assign bus.busy    = (r_state != IDLE);

endmodule
`default_nettype wire
